// File: rtl/calc_pkg.sv
// Shared definitions for the calculator multiply path.
// Contents:
//   CALC_WIDTH - operand width of the multiply datapath (fixed at 16)
//   CNT_W      - bit-step counter width, $clog2(CALC_WIDTH)
//   state_t    - multiplier controller FSM encoding (2-bit)
//   mag()      - unsigned magnitude of an operand when signed mode is active
package calc_pkg;

    localparam int unsigned CALC_WIDTH = 16;
    localparam int unsigned CNT_W      = $clog2(CALC_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // |v| for a two's-complement value when en=1, v unchanged otherwise.
    // The most negative value maps to itself, which is its correct unsigned magnitude.
    function automatic logic [CALC_WIDTH-1:0] mag(input logic [CALC_WIDTH-1:0] v,
                                                  input logic                  en);
        return (en && v[CALC_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/seq_multiply_ctrl_andmultiply.sv
// andmultiply: partial-product generator, one multiplier bit against the multiplicand.
// Ports:
//   A  in  16  multiplicand
//   B  in  1   current multiplier bit
//   P  out 16  A when B=1, zero otherwise
module andmultiply
    import calc_pkg::*;
(
    input  logic [CALC_WIDTH-1:0] A,
    input  logic                  B,
    output logic [CALC_WIDTH-1:0] P
);

    assign P = A & {CALC_WIDTH{B}};

endmodule

// File: rtl/seq_multiply_ctrl.sv
// seq_multiply_ctrl: sequential shift-add multiplier controller.
// Retires one multiplier bit per clock through a single andmultiply instance,
// then applies the sign fix-up; fixed 17-clock latency from the start edge.
// Ports:
//   clk      in   1        system clock, rising edge
//   rst_n    in   1        asynchronous reset, active low
//   start    in   1        request, sampled only when idle
//   sgn      in   1        operands are two's complement (ignored when SIGNED_EN=0)
//   a        in   WIDTH    multiplicand
//   b        in   WIDTH    multiplier
//   busy     out  1        operation in flight (through the sign-fix cycle)
//   done     out  1        one-cycle pulse, product valid
//   product  out  2*WIDTH  result, held until the next operation completes
module seq_multiply_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH     = CALC_WIDTH,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    if (WIDTH != CALC_WIDTH) begin : g_width_chk
        $error("seq_multiply_ctrl: WIDTH must be 16 to match andmultiply");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [WIDTH-1:0]      r_mcand;
    logic [WIDTH-1:0]      r_mplr;     // multiplier bits shift out, product low half shifts in
    logic [WIDTH-1:0]      r_acc_hi;
    logic                  r_neg;
    logic                  r_busy;
    logic                  r_done;
    logic [2*WIDTH-1:0]    r_product;

    logic                  w_signed;
    logic [WIDTH-1:0]      w_pp;
    logic [WIDTH:0]        w_sum;
    logic [2*WIDTH-1:0]    w_acc;
    logic [2*WIDTH-1:0]    w_fixed;

    assign w_signed = SIGNED_EN && sgn;

    andmultiply u_pp (
        .A (r_mcand),
        .B (r_mplr[0]),
        .P (w_pp)
    );

    assign w_sum   = {1'b0, r_acc_hi} + {1'b0, w_pp};
    assign w_acc   = {r_acc_hi, r_mplr};
    assign w_fixed = r_neg ? -w_acc : w_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc_hi  <= '0;
            r_neg     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= mag(a, w_signed);
                        r_mplr   <= mag(b, w_signed);
                        r_neg    <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // {acc_hi, mplr} <= {sum, mplr} >> 1
                    r_acc_hi <= w_sum[WIDTH:1];
                    r_mplr   <= {w_sum[0], r_mplr[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_product <= w_fixed;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_seq_multiply_ctrl.sv
module tb_seq_multiply_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sgn;
    logic [15:0] a, b;
    logic        busy, done;
    logic [31:0] product;

    // unsigned-only instance
    logic        start2, sgn2;
    logic [15:0] a2, b2;
    logic        busy2, done2;
    logic [31:0] product2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_multiply_ctrl #(.WIDTH(16), .SIGNED_EN(1'b1)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sgn     (sgn),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    seq_multiply_ctrl #(.WIDTH(16), .SIGNED_EN(1'b0)) u_dut_u (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start2),
        .sgn     (sgn2),
        .a       (a2),
        .b       (b2),
        .busy    (busy2),
        .done    (done2),
        .product (product2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation on the signed-capable instance: latency, busy length, product.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          input logic [31:0] exp, input string tag);
        int  lat;
        int  nbusy;
        bit  seen;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; sgn = ts;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; nbusy = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (busy) nbusy++;
            if (busy && done) check({tag, "_busy_and_done"}, 1, 0);
            if (done) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                @(posedge clk); #1;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 1);
        check({tag, "_latency"}, 64'(lat), 17);
        check({tag, "_busy_cycles"}, 64'(nbusy), 17);
        check({tag, "_product"}, 64'(product), 64'(exp));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(done), 0);
        check({tag, "_product_hold"}, 64'(product), 64'(exp));
    endtask

    initial begin
        int          ndone;
        int          dcyc;
        int          d1, d2;
        logic [31:0] p_mid;

        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        start2 = 1'b0; sgn2 = 1'b0; a2 = '0; b2 = '0;
        #12;
        check("reset_busy", 64'(busy), 0);
        check("reset_done", 64'(done), 0);
        check("reset_product", 64'(product), 0);
        @(negedge clk); rst_n = 1'b1;

        // 1. unsigned full-scale
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "t1_ffff_sq");
        // 2. signed/unsigned interpretation of the same bits
        run_op(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, "t2_s_m3x5");
        run_op(16'hFFFD, 16'h0005, 1'b0, 32'h0004FFF1, "t2_u_fffdx5");
        // 3. signed boundaries and zero operand
        run_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, "t3_min_sq");
        run_op(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, "t3_min_x1");
        run_op(16'h0000, 16'h1234, 1'b1, 32'h00000000, "t3_zero");

        // 4. start pulses while busy are ignored
        @(negedge clk);
        start = 1'b1; a = 16'd12; b = 16'd10; sgn = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; dcyc = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                dcyc = c;
            end
            if (busy && done) check("t4_busy_and_done", 1, 0);
            if (c >= 2 && c <= 9) begin
                start = 1'b1;
                a = 16'($urandom);
                b = 16'($urandom);
                sgn = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        check("t4_done_count", 64'(ndone), 1);
        check("t4_done_cycle", 64'(dcyc), 17);
        check("t4_product", 64'(product), 64'h78);

        // 5. async reset mid-run aborts
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sgn = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check("t5_busy_before_rst", 64'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 64'(busy), 0);
        check("t5_rst_done", 64'(done), 0);
        check("t5_rst_product", 64'(product), 0);
        @(negedge clk); rst_n = 1'b1;
        run_op(16'd7, 16'd6, 1'b0, 32'h0000002A, "t5_after_rst");

        // 6. start held high: back-to-back operations every 18 clocks
        @(negedge clk);
        start = 1'b1; a = 16'd3; b = 16'd5; sgn = 1'b0;
        @(posedge clk); #1;
        d1 = -1; d2 = -1; ndone = 0;
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (d1 < 0) d1 = c; else d2 = c;
            end
            if (c == 10) begin
                p_mid = product;
                check("t6_hold_before_first", 64'(p_mid), 64'h2A);
            end
            if (c == 17) begin
                check("t6_first_product", 64'(product), 64'd15);
                a = 16'd4;
            end
            if (c == 25) check("t6_hold_before_second", 64'(product), 64'd15);
            if (c == 35) start = 1'b0;
        end
        check("t6_done_count", 64'(ndone), 2);
        check("t6_first_done", 64'(d1), 17);
        check("t6_second_done", 64'(d2), 35);
        check("t6_second_product", 64'(product), 64'd20);

        // 6b. SIGNED_EN=0 ignores sgn
        @(negedge clk);
        start2 = 1'b1; a2 = 16'hFFFF; b2 = 16'h0002; sgn2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("t6b_not_done_early", 64'(done2), 0);
        @(posedge clk); #1;
        check("t6b_done", 64'(done2), 1);
        check("t6b_product", 64'(product2), 64'h0001FFFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
